// File: rtl/rca_seq_ctrl.sv
// Wide adder sequencer: adds two 4*NIBBLES-bit operands one nibble per clock,
// LSB first, through a single external 4-bit ripple-carry adder slice.
module rca_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout_out,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [W-1:0]     opa_q;
    logic [W-1:0]     opb_q;

    // Bit offset of the active nibble; idx*4 built by concatenation.
    logic [IDX_W+1:0] base;
    assign base = {idx, 2'b00};

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = opa_q[base +: 4];
            add_b   = opb_q[base +: 4];
            add_cin = carry;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa_q  <= op_a;
                        opb_q  <= op_b;
                        carry  <= cin;
                        idx    <= '0;
                        result <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    result[base +: 4] <= add_sum;
                    carry             <= add_cout;
                    if (idx == LAST_IDX) begin
                        cout_out <= add_cout;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl with NIBBLES=4 and a behavioural 4-bit
// adder slice closing the loop on add_a/add_b/add_cin.
module tb_rca_seq_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout_out;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    rca_seq_ctrl #(.NIBBLES(NIB)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout_out (cout_out),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // Expected carry into each nibble, derived from partial sums of the operands.
    function automatic logic [NIB-1:0] exp_carries(input logic [W-1:0] a,
                                                   input logic [W-1:0] b,
                                                   input logic c);
        logic [NIB-1:0] r;
        longint mask;
        longint lo;
        for (int k = 0; k < NIB; k++) begin
            mask = (64'd1 << (4 * k)) - 1;
            lo   = (longint'(a) & mask) + (longint'(b) & mask) + longint'(c);
            r[k] = lo[4 * k];
        end
        return r;
    endfunction

    // One full operation from an idle cycle; operands are scrambled after the
    // accepting edge to show they are not re-sampled.
    task automatic do_op(input string name, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic c,
                         input logic [W-1:0] exp_res, input logic exp_co);
        int k;
        int bc;
        logic [NIB-1:0] trace;
        logic [NIB-1:0] exp_tr;
        @(negedge clk);
        op_a = a; op_b = b; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op_a = ~a; op_b = ~b; cin = ~c;
        k = 0; bc = 0; trace = '0;
        while (!done && k < 20) begin
            if (busy) begin
                bc++;
                if (k < NIB) trace[k] = add_cin;
            end
            @(negedge clk);
            k++;
        end
        exp_tr = exp_carries(a, b, c);
        n_cmp++;
        if (k !== NIB) begin
            n_mis++;
            $display("FAIL %s latency: done after %0d edges, expected %0d", name, k, NIB);
        end
        n_cmp++;
        if (bc !== NIB) begin
            n_mis++;
            $display("FAIL %s busy_cycles: got %0d, expected %0d", name, bc, NIB);
        end
        n_cmp++;
        if (result !== exp_res || cout_out !== exp_co) begin
            n_mis++;
            $display("FAIL %s result: got %0b_%h, expected %0b_%h", name, cout_out, result, exp_co, exp_res);
        end
        n_cmp++;
        if (trace !== exp_tr) begin
            n_mis++;
            $display("FAIL %s carry_trace: got %b, expected %b", name, trace, exp_tr);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_mis++;
            $display("FAIL %s busy_at_done: got %b, expected 0", name, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || result !== exp_res || cout_out !== exp_co) begin
            n_mis++;
            $display("FAIL %s after_done: done=%b result=%h cout=%b, expected done=0 result=%h cout=%b",
                     name, done, result, cout_out, exp_res, exp_co);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, cout_out, result} !== '0) begin
            n_mis++;
            $display("FAIL reset_outputs: busy=%b done=%b cout=%b result=%h, expected all 0",
                     busy, done, cout_out, result);
        end
        n_cmp++;
        if ({add_a, add_b, add_cin} !== '0) begin
            n_mis++;
            $display("FAIL reset_adder_drive: a=%h b=%h cin=%b, expected 0", add_a, add_b, add_cin);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        do_op("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_carry_chain();
        do_op("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    endtask

    task automatic test_mixed();
        do_op("mixed_ee_cc", 16'hEEEE, 16'hCCCC, 1'b0, 16'hBBBA, 1'b1);
        do_op("mixed_cin", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
    endtask

    // start pulses during RUN and during DONE must both be dropped.
    task automatic test_ignored_start();
        int dones;
        int busies;
        @(negedge clk);
        op_a = 16'h0007; op_b = 16'h0007; cin = 1'b0; start = 1'b1;
        @(negedge clk);                      // after edge 0
        start = 1'b0;
        @(negedge clk);                      // after edge 1
        op_a = 16'h1111; start = 1'b1;
        @(negedge clk);                      // after edge 2
        start = 1'b0;
        dones = 0;
        for (int i = 3; i < 14; i++) begin
            @(negedge clk);                  // after edge i
            if (done) dones++;
            if (i == 4) begin
                n_cmp++;
                if (done !== 1'b1 || result !== 16'h000E || cout_out !== 1'b0) begin
                    n_mis++;
                    $display("FAIL ignored_start result: done=%b result=%h cout=%b, expected 1/000e/0",
                             done, result, cout_out);
                end
                start = 1'b1;                // sampled at edge 5 while in DONE
            end
            if (i == 5) start = 1'b0;
            if (i >= 5 && busy) busies++;
        end
        n_cmp++;
        if (dones !== 1) begin
            n_mis++;
            $display("FAIL ignored_start done_count: got %0d, expected 1", dones);
        end
        n_cmp++;
        if (busies !== 0 || result !== 16'h000E) begin
            n_mis++;
            $display("FAIL ignored_start no_restart: busy_cycles=%0d result=%h, expected 0/000e",
                     busies, result);
        end
    endtask

    task automatic test_reset_mid_op();
        int dones;
        @(negedge clk);
        op_a = 16'h0F0F; op_b = 16'h0F0F; cin = 1'b1; start = 1'b1;
        @(negedge clk);                      // after edge 0
        start = 1'b0;
        @(negedge clk);                      // after edge 1
        rst = 1'b1;
        @(negedge clk);                      // after edge 2 (reset sampled)
        rst = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || result !== '0 || cout_out !== 1'b0 || done !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_mid_op state: busy=%b result=%h cout=%b done=%b, expected all 0",
                     busy, result, cout_out, done);
        end
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_mis++;
            $display("FAIL reset_mid_op no_done: got %0d active cycles, expected 0", dones);
        end
        do_op("after_reset", 16'h0101, 16'h0202, 1'b0, 16'h0303, 1'b0);
    endtask

    task automatic test_back_to_back();
        int d[$];
        int low;
        int bad_res;
        @(negedge clk);
        op_a = 16'h0001; op_b = 16'h0002; cin = 1'b0; start = 1'b1;
        low = 0; bad_res = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);                  // after edge i
            if (done) begin
                d.push_back(i);
                if (result !== 16'h0003 || cout_out !== 1'b0) bad_res++;
            end
            if (d.size() == 1 && !busy) low++;
        end
        start = 1'b0;
        n_cmp++;
        if (d.size() !== 3) begin
            n_mis++;
            $display("FAIL back_to_back done_count: got %0d, expected 3", d.size());
        end else begin
            n_cmp++;
            if (d[1] - d[0] !== 6 || d[2] - d[1] !== 6) begin
                n_mis++;
                $display("FAIL back_to_back spacing: got %0d,%0d, expected 6,6", d[1] - d[0], d[2] - d[1]);
            end
        end
        n_cmp++;
        if (low !== 2) begin
            n_mis++;
            $display("FAIL back_to_back busy_gap: got %0d low cycles, expected 2", low);
        end
        n_cmp++;
        if (bad_res !== 0) begin
            n_mis++;
            $display("FAIL back_to_back result: %0d wrong results, expected 0", bad_res);
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_carry_chain();
        test_mixed();
        test_ignored_start();
        test_reset_mid_op();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
